// File: rtl/data_memory_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_memory_controller_if                                     |
// | Purpose  : Request/response and SRAM-port bundle for the data-memory     |
// |            controller. The master side is the pipeline together with the |
// |            SRAM array; the slave side is the controller itself.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface data_memory_controller_if #(
  parameter int ADDR_WIDTH = 14
);
  // Pipeline request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_width;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;

  // Completion channel
  logic                  resp_valid;
  logic [31:0]           resp_rdata;

  // Single-port synchronous SRAM
  logic                  sram_en;
  logic                  sram_we;
  logic [3:0]            sram_be;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;

  modport master (
    output req_valid, req_we, req_width, req_unsigned, req_addr, req_wdata,
    output sram_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  sram_en, sram_we, sram_be, sram_addr, sram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_width, req_unsigned, req_addr, req_wdata,
    input  sram_rdata,
    output req_ready, resp_valid, resp_rdata,
    output sram_en, sram_we, sram_be, sram_addr, sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_memory_controller                                        |
// | Purpose  : One-request-at-a-time load/store controller for a 32-bit      |
// |            byte-enabled synchronous SRAM. Splits word-crossing accesses  |
// |            into two SRAM cycles and aligns/extends load data.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module data_memory_controller #(
  parameter int ADDR_WIDTH   = 14,
  parameter int MEMORY_WIDTH = 32
) (
  input wire clk,
  input wire rst,
  data_memory_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_SECOND = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  // Latched request fields
  logic                    r_we;
  logic                    r_unsigned;
  logic [1:0]              r_width;
  logic [1:0]              r_off;
  logic [ADDR_WIDTH-1:0]   r_widx;
  logic [7:0]              r_mask;
  logic [MEMORY_WIDTH-1:0] r_wdata;
  logic [MEMORY_WIDTH-1:0] r_lo;
  logic [MEMORY_WIDTH-1:0] r_resp_rdata;

  logic                    w_can_accept;
  logic                    w_accept;
  logic [7:0]              w_mask_base;
  logic [7:0]              w_mask8;
  logic                    w_span;
  logic [5:0]              w_hi_shamt;
  logic [MEMORY_WIDTH-1:0] w_lo;
  logic [MEMORY_WIDTH-1:0] w_hi;
  logic [MEMORY_WIDTH-1:0] w_raw;
  logic [MEMORY_WIDTH-1:0] w_load;
  logic                    w_unused;

  // Only the word-address bits that reach the SRAM are meaningful.
  assign w_unused = &{1'b0, bus.req_addr[31:ADDR_WIDTH+2]};

  // The controller takes a new request only when no access is in flight.
  assign w_can_accept   = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_accept       = bus.req_valid && w_can_accept && (bus.req_width != 2'd0);
  assign bus.req_ready  = w_can_accept;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_resp_rdata;

  // An access spans two words when any selected byte falls past lane 3.
  assign w_span     = |r_mask[7:4];
  assign w_hi_shamt = {3'd4 - {1'b0, r_off}, 3'b000};

  // Byte mask of the incoming request, before it is latched.
  always_comb begin
    w_mask_base = 8'h00;
    case (bus.req_width)
      2'd1:    w_mask_base = 8'h01;
      2'd2:    w_mask_base = 8'h03;
      2'd3:    w_mask_base = 8'h0F;
      default: w_mask_base = 8'h00;
    endcase
    w_mask8 = w_mask_base << bus.req_addr[1:0];
  end

  // Load assembly: the word read back in WAIT is the high half of a split access.
  always_comb begin
    w_lo   = w_span ? r_lo : bus.sram_rdata;
    w_hi   = w_span ? bus.sram_rdata : '0;
    w_raw  = MEMORY_WIDTH'({w_hi, w_lo} >> {r_off, 3'b000});
    w_load = w_raw;
    case (r_width)
      2'd1:    w_load = r_unsigned ? {24'd0, w_raw[7:0]}  : {{24{w_raw[7]}}, w_raw[7:0]};
      2'd2:    w_load = r_unsigned ? {16'd0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
      default: w_load = w_raw;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and SRAM port drive; the port is all zeros when idle.
  always_comb begin
    w_next_state   = r_state;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_be    = 4'b0000;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_FIRST;
        end
      end
      S_FIRST: begin
        bus.sram_en    = 1'b1;
        bus.sram_we    = r_we;
        bus.sram_addr  = r_widx;
        bus.sram_be    = r_mask[3:0];
        bus.sram_wdata = r_wdata << {r_off, 3'b000};
        w_next_state   = w_span ? S_SECOND : S_WAIT;
      end
      S_SECOND: begin
        bus.sram_en    = 1'b1;
        bus.sram_we    = r_we;
        bus.sram_addr  = r_widx + ADDR_WIDTH'(1);
        bus.sram_be    = r_mask[7:4];
        bus.sram_wdata = r_wdata >> w_hi_shamt;
        w_next_state   = S_WAIT;
      end
      S_WAIT: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        w_next_state = w_accept ? S_FIRST : S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request latch, low-word capture and response data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_width      <= 2'd0;
      r_off        <= 2'd0;
      r_widx       <= '0;
      r_mask       <= 8'h00;
      r_wdata      <= '0;
      r_lo         <= '0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we       <= bus.req_we;
        r_unsigned <= bus.req_unsigned;
        r_width    <= bus.req_width;
        r_off      <= bus.req_addr[1:0];
        r_widx     <= bus.req_addr[ADDR_WIDTH+1:2];
        r_mask     <= w_mask8;
        r_wdata    <= bus.req_wdata;
      end
      if (r_state == S_SECOND) begin
        r_lo <= bus.sram_rdata;
      end
      if (r_state == S_WAIT) begin
        r_resp_rdata <= r_we ? '0 : w_load;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_memory_controller                                     |
// | Purpose  : Scoreboard bench for data_memory_controller with a byte-level |
// |            reference memory and a behavioural SRAM.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_data_memory_controller;
  localparam int AW = 14;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic          we;
    logic [31:0]   wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cycle = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rdata = '0;
  resp_t       resp_q[$];
  acc_t        acc_q[$];
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] sram [0:(1<<AW)-1];
  logic [31:0] sram_q;

  always #5 clk = ~clk;

  data_memory_controller_if #(.ADDR_WIDTH(AW)) bus ();

  data_memory_controller #(.ADDR_WIDTH(AW), .MEMORY_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port SRAM, read data valid the cycle after the enable.
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sram_be[b]) sram[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
      end
      sram_q <= sram[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = sram_q;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops expected SRAM accesses and responses as the DUT presents them.
  initial forever begin
    resp_t r;
    acc_t  a;
    @(negedge clk);
    if (bus.resp_valid) begin
      if (resp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        r = resp_q.pop_front();
        check("resp_rdata", bus.resp_rdata, r.rdata);
        check("resp_cycle", cycle, r.cyc);
        last_rdata = bus.resp_rdata;
      end
    end
    if (bus.sram_en) begin
      if (acc_q.size() == 0) begin
        check("sram_unexpected", 32'd1, 32'd0);
      end else begin
        a = acc_q.pop_front();
        check("sram_addr", 32'(bus.sram_addr), 32'(a.addr));
        check("sram_be", 32'(bus.sram_be), 32'(a.be));
        check("sram_we", 32'(bus.sram_we), 32'(a.we));
        check("sram_wdata", bus.sram_wdata, a.wdata);
      end
    end else begin
      check("sram_idle_ctl", 32'({bus.sram_we, bus.sram_be, bus.sram_addr}), 32'd0);
      check("sram_idle_wdata", bus.sram_wdata, 32'd0);
    end
  end

  // Issue one request and record what the memory and pipeline should see.
  task automatic issue(input logic we, input logic [1:0] width, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int          guard;
    int          nb;
    int          off;
    int          a16;
    logic        span;
    logic [31:0] exp;
    resp_t       r;
    acc_t        a0;
    acc_t        a1;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_width    = width;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    if (width != 2'd0) begin
      nb   = (width == 2'd3) ? 4 : int'(width);
      a16  = int'(addr & 32'hFFFF);
      off  = int'(addr & 32'h3);
      span = (off + nb) > 4;
      a0.addr  = AW'(a16 >> 2);
      a1.addr  = a0.addr + 1'b1;
      a0.we    = we;
      a1.we    = we;
      a0.be    = 4'b0000;
      a1.be    = 4'b0000;
      for (int i = 0; i < nb; i++) begin
        if (off + i < 4) a0.be[off+i] = 1'b1;
        else             a1.be[off+i-4] = 1'b1;
      end
      a0.wdata = wdata << (8 * off);
      a1.wdata = span ? (wdata >> (8 * (4 - off))) : 32'd0;
      acc_q.push_back(a0);
      if (span) acc_q.push_back(a1);
      exp = 32'd0;
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[(a16 + i) & 16'hFFFF] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) exp[8*i +: 8] = ref_mem[(a16 + i) & 16'hFFFF];
        if (!uns && nb == 1 && exp[7])  exp[31:8]  = 24'hFFFFFF;
        if (!uns && nb == 2 && exp[15]) exp[31:16] = 16'hFFFF;
      end
      r.rdata = exp;
      r.cyc   = cycle + 1 + (span ? 3 : 2);
      resp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_width = 2'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && resp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", resp_q.size(), 32'd0);
  endtask

  task automatic load_expect(input logic [1:0] width, input logic uns, input logic [31:0] addr,
                             input logic [31:0] exp, input string name);
    issue(1'b0, width, uns, addr, 32'd0);
    drain();
    check(name, last_rdata, exp);
  endtask

  initial begin
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_width    = 2'd3;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h100;
    bus.req_wdata    = 32'h12345678;

    // Reset values, with a request held on the bus that must be ignored.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_sram_en", 32'(bus.sram_en), 32'd0);
    bus.req_valid = 1'b0;
    bus.req_width = 2'd0;
    rst = 1'b0;

    // Aligned word
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'hDEADBEEF);
    load_expect(2'd3, 1'b0, 32'h100, 32'hDEADBEEF, "lw_aligned");

    // Byte lane and extension
    issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h00000080);
    load_expect(2'd1, 1'b0, 32'h102, 32'hFFFFFF80, "lb_signed");
    load_expect(2'd1, 1'b1, 32'h102, 32'h00000080, "lbu");

    // Halfword
    issue(1'b1, 2'd2, 1'b0, 32'h202, 32'h00008001);
    load_expect(2'd2, 1'b0, 32'h202, 32'hFFFF8001, "lh_signed");
    load_expect(2'd2, 1'b1, 32'h202, 32'h00008001, "lhu");

    // Spanning word load and store
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'h44332211);
    issue(1'b1, 2'd3, 1'b0, 32'h104, 32'h88776655);
    load_expect(2'd3, 1'b0, 32'h103, 32'h77665544, "lw_span");
    issue(1'b1, 2'd3, 1'b0, 32'h103, 32'hAABBCCDD);
    load_expect(2'd3, 1'b0, 32'h103, 32'hAABBCCDD, "lw_span_after_sw");

    // Address wrap at the top word, upper address bits ignored
    issue(1'b1, 2'd2, 1'b0, 32'h1234FFFF, 32'h0000BEEF);
    load_expect(2'd2, 1'b0, 32'h0000FFFF, 32'hFFFFBEEF, "lh_wrap");

    // A width-0 request is not an access
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_width = 2'd0;
    bus.req_addr  = 32'h100;
    @(posedge clk);
    #1;
    check("w0_req_ready", 32'(bus.req_ready), 32'd1);
    check("w0_sram_en", 32'(bus.sram_en), 32'd0);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during the second half of a spanning load
    issue(1'b0, 2'd3, 1'b0, 32'h103, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_sram_en", 32'(bus.sram_en), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    resp_q.delete();
    acc_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    load_expect(2'd3, 1'b0, 32'h103, 32'hAABBCCDD, "lw_after_reset");

    // Fill 0x100..0x1FF, then random traffic confined to it
    for (int w = 0; w < 64; w++) issue(1'b1, 2'd3, 1'b0, 32'h100 + 32'(4 * w), $urandom);
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [1:0]  width;
      logic [31:0] addr;
      we    = 1'($urandom_range(0, 1));
      width = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      addr  = {16'($urandom), 16'h0100 + 16'($urandom_range(0, 252))};
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(we, width, 1'($urandom_range(0, 1)), addr, we ? $urandom : 32'd0);
    end
    drain();
    repeat (2) @(negedge clk);
    check("acc_queue_empty", acc_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
